stream_pair_harness: RTL and testbench
======================================

Name: stream_pair_harness

Overview:
- Parametrised operand/result harness between two operand sources, a two-input stb/ack arithmetic unit (e.g. the FP multiplier) and a result sink.
- Buffers each operand stream and the result stream in DEPTH-entry FIFOs and pairs a/b operands in order.
- Issues pairs to the unit only when result space is guaranteed, and counts issued and completed transactions.
- Replaces direct point-to-point wiring in benches and system tops, so sources and sink no longer stall the unit.

Parameters:
WIDTH, 32, data width of every stream
DEPTH, 4, entries per FIFO (power of 2, >=2); also the limit on issued-but-unread results
CNT_W, 16, width of transaction counters
TIMEOUT, 1024, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
input_a  in  WIDTH  operand a data
input_a_stb  in  1  operand a valid
input_a_ack  out  1  operand a accepted
input_b  in  WIDTH  operand b data
input_b_stb  in  1  operand b valid
input_b_ack  out  1  operand b accepted
unit_a  out  WIDTH  operand a to unit
unit_a_stb  out  1  operand a valid to unit
unit_a_ack  in  1  unit accepted a
unit_b  out  WIDTH  operand b to unit
unit_b_stb  out  1  operand b valid to unit
unit_b_ack  in  1  unit accepted b
unit_z  in  WIDTH  result from unit
unit_z_stb  in  1  result valid
unit_z_ack  out  1  result accepted
output_z  out  WIDTH  result to sink
output_z_stb  out  1  result valid to sink
output_z_ack  in  1  sink accepted
issued_count  out  CNT_W  pairs fully issued to unit
completed_count  out  CNT_W  results delivered to sink
timeout  out  1  watchdog flag (optional feature)

Behaviour:
- Single clock domain clk. Reset is synchronous, active-high on rst.
- Handshake on every stream:
  - A transfer occurs on the rising edge where stb and ack are both high.
  - The sender holds stb high and data stable until the transfer.
  - Either side may raise its signal first.
- All outputs are driven from registers only. There is no combinational path from any input to any output.
- Reset:
  - All FIFOs empty; issue FSM in IDLE.
  - in_flight=0; counters=0; timeout=0.
  - All stb and ack outputs = 0.
  - Data outputs = 0.
- Input FIFOs A and B:
  - input_x_ack = 1 iff FIFO x is not full.
  - Write on transfer.
  - Pointers wrap modulo DEPTH; a full/empty distinction bit is kept.
  - Simultaneous push and pop on a full or empty FIFO is legal; occupancy stays consistent.
- Issue FSM:
  - IDLE -> ISSUE when A and B are both non-empty and in_flight + occ_Z < DEPTH (credit check).
  - On entry to ISSUE:
    - Latch unit_a = head A, unit_b = head B.
    - Assert unit_a_stb and unit_b_stb.
    - Clear the sent_a and sent_b flags.
  - In ISSUE, each operand is handshaken independently:
    - unit_a transfer -> set sent_a; drop unit_a_stb next cycle.
    - unit_b transfer -> same for sent_b and unit_b_stb.
  - When both operands have been sent (same edge or different edges):
    - Pop A and B.
    - in_flight += 1; issued_count += 1.
    - Return to IDLE.
  - Minimum one bubble cycle between pairs.
  - Latency: word written into empty A/B on edge T -> unit_x_stb high from T+2.
- Result side:
  - unit_z_ack = 1 iff in_flight > 0.
  - The credit check guarantees FIFO Z is never full when a result arrives.
  - Result transfer: push Z; in_flight -= 1.
  - Issue completion and result transfer on the same edge: in_flight is unchanged.
  - A unit_z_stb arriving while in_flight = 0 is ignored (ack stays 0).
- Output:
  - output_z_stb = 1 iff FIFO Z is non-empty; output_z = head Z.
  - Sink transfer: pop Z; completed_count += 1.
  - Result accepted on edge T into empty Z -> output_z_stb high from T+1.
- Counters wrap modulo 2^CNT_W with no saturation.
- Ordering: results are delivered in arrival order. The unit is assumed in-order, and pair k is formed from the k-th a and the k-th b.
- Reset mid-operation:
  - Discards all buffered and in-flight data.
  - Outputs return to reset values on the following edge, regardless of handshake state.

Optional Feature:
- Macro: HARNESS_WATCHDOG_EN
- Defined:
  - A counter runs while in_flight > 0 and no unit_z transfer occurs.
  - It clears on any unit_z transfer, or when in_flight = 0.
  - On reaching TIMEOUT it sets timeout = 1.
  - timeout is sticky and cleared only by rst.
  - Data flow is unaffected.
- Undefined: timeout is tied 0, no watchdog logic is built, and TIMEOUT is unused.

Test Plan:
- Single pair: a=0x40000000, b=0x40400000, unit model returns 0x40C00000 after 5 cycles, sink acks immediately -> output_z=0x40C00000; issued_count=1, completed_count=1; unit_x_stb first high 2 cycles after the input write.
- Skewed operands: 6 a-words sent 20 cycles before any b-word, DEPTH=4 -> input_a_ack low after 4 accepted; pairs issued in order once b arrives; 6 results match the reference products in order.
- Sink backpressure: output_z_ack held 0 while 10 pairs are offered -> at most DEPTH pairs issued (issued_count=4); unit_z_ack never high with Z full; on release all 10 delivered in order; completed_count=10.
- Independent unit acks: unit_b_ack 3 cycles after unit_a_ack, then both on the same edge for the next pair -> each pair popped once; in_flight increments by exactly 1 per pair.
- Counter wrap with CNT_W=4: 17 transactions -> issued_count=1, completed_count=1.
- Reset mid-flight (3 in FIFO A, 1 in flight) -> next cycle all stb/ack outputs 0, counters 0. With HARNESS_WATCHDOG_EN and TIMEOUT=16, a unit that never returns sets timeout at cycle 16 of waiting and keeps it set until rst.

Source files
------------

// File: rtl/stream_pair_harness.sv
// stream_pair_harness: decouples two operand sources, a two-input stb/ack
// arithmetic unit and a result sink. Operand streams a and b and the result
// stream are each buffered in a DEPTH-entry FIFO. Operands are paired in
// order, and a pair is issued only when a result slot is guaranteed.
// Define HARNESS_WATCHDOG_EN to build the result watchdog that drives
// timeout. Without it, timeout is held low.

module stream_pair_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   occ
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   // The extra pointer bit separates full from empty when the indices match.
   assign occ     = wr_ptr - rd_ptr;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (occ == FULL_OCC);
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr[AW-1:0]];

   // Advance the pointers. The extra bit wraps naturally modulo 2*DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage is not reset. Empty entries are never presented as valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end
endmodule

module stream_pair_harness #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 4,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  input_a,
   input  logic              input_a_stb,
   output logic              input_a_ack,
   input  logic [WIDTH-1:0]  input_b,
   input  logic              input_b_stb,
   output logic              input_b_ack,
   output logic [WIDTH-1:0]  unit_a,
   output logic              unit_a_stb,
   input  logic              unit_a_ack,
   output logic [WIDTH-1:0]  unit_b,
   output logic              unit_b_stb,
   input  logic              unit_b_ack,
   input  logic [WIDTH-1:0]  unit_z,
   input  logic              unit_z_stb,
   output logic              unit_z_ack,
   output logic [WIDTH-1:0]  output_z,
   output logic              output_z_stb,
   input  logic              output_z_ack,
   output logic [CNT_W-1:0]  issued_count,
   output logic [CNT_W-1:0]  completed_count,
   output logic              timeout
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_OCC = (AW+1)'(DEPTH);
   localparam logic [AW+1:0] CREDITS  = (AW+2)'(DEPTH);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t           state;
   logic             run;
   logic             sent_a;
   logic             sent_b;
   logic [AW:0]      in_flight;
   logic [WIDTH-1:0] head_a, head_b, head_z;
   logic             empty_a, empty_b, empty_z;
   logic [AW:0]      occ_a, occ_b, occ_z;
   logic             push_a, push_b, push_z, pop_z;
   logic             a_xfer, b_xfer, issue_done;
   logic [AW+1:0]    credit_sum;
   logic             credit_ok;

   // Input acks are held low for the first cycle after reset because run is
   // still clear. This keeps every ack at 0 in the cycle after reset.
   assign input_a_ack  = run && (occ_a != FULL_OCC);
   assign input_b_ack  = run && (occ_b != FULL_OCC);
   assign unit_z_ack   = (in_flight != '0);
   assign output_z_stb = !empty_z;
   assign output_z     = empty_z ? '0 : head_z;

   assign push_a     = input_a_stb && input_a_ack;
   assign push_b     = input_b_stb && input_b_ack;
   assign push_z     = unit_z_stb && unit_z_ack;
   assign pop_z      = output_z_stb && output_z_ack;
   assign a_xfer     = unit_a_stb && unit_a_ack;
   assign b_xfer     = unit_b_stb && unit_b_ack;
   assign issue_done = (state == ISSUE) && (sent_a || a_xfer) && (sent_b || b_xfer);

   // A result slot is reserved for every pair that is in flight or waiting in Z.
   assign credit_sum = {1'b0, in_flight} + {1'b0, occ_z};
   assign credit_ok  = (credit_sum < CREDITS);

   stream_pair_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) fifo_a (
      .clk(clk), .rst(rst), .push(push_a), .din(input_a), .pop(issue_done),
      .head(head_a), .empty(empty_a), .occ(occ_a));

   stream_pair_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) fifo_b (
      .clk(clk), .rst(rst), .push(push_b), .din(input_b), .pop(issue_done),
      .head(head_b), .empty(empty_b), .occ(occ_b));

   stream_pair_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) fifo_z (
      .clk(clk), .rst(rst), .push(push_z), .din(unit_z), .pop(pop_z),
      .head(head_z), .empty(empty_z), .occ(occ_z));

   // Input acks are enabled one cycle after reset is released.
   always_ff @(posedge clk) begin
      if (rst) run <= 1'b0;
      else     run <= 1'b1;
   end

   // Issue FSM: latch the head pair, then hand each operand over independently.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         unit_a       <= '0;
         unit_b       <= '0;
         unit_a_stb   <= 1'b0;
         unit_b_stb   <= 1'b0;
         sent_a       <= 1'b0;
         sent_b       <= 1'b0;
         issued_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!empty_a && !empty_b && credit_ok) begin
                  state      <= ISSUE;
                  unit_a     <= head_a;
                  unit_b     <= head_b;
                  unit_a_stb <= 1'b1;
                  unit_b_stb <= 1'b1;
                  sent_a     <= 1'b0;
                  sent_b     <= 1'b0;
               end
            end
            ISSUE: begin
               if (a_xfer) begin
                  sent_a     <= 1'b1;
                  unit_a_stb <= 1'b0;
               end
               if (b_xfer) begin
                  sent_b     <= 1'b1;
                  unit_b_stb <= 1'b0;
               end
               if (issue_done) begin
                  state        <= IDLE;
                  issued_count <= issued_count + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Track pairs that have been handed to the unit but whose result has not yet arrived.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_flight <= '0;
      end else begin
         case ({issue_done, push_z})
            2'b10:   in_flight <= in_flight + 1'b1;
            2'b01:   in_flight <= in_flight - 1'b1;
            default: in_flight <= in_flight;
         endcase
      end
   end

   // Count results delivered to the sink. The count wraps freely.
   always_ff @(posedge clk) begin
      if (rst)        completed_count <= '0;
      else if (pop_z) completed_count <= completed_count + 1'b1;
   end

`ifdef HARNESS_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LIM  = WD_W'(TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   logic [WD_W-1:0] wd_cnt;
   logic            wd_run;
   logic            timeout_r;

   assign wd_run  = (in_flight != '0) && !push_z;
   assign timeout = timeout_r;

   // Measure how long the unit has been silent while results are owed. The flag is sticky.
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt    <= '0;
         timeout_r <= 1'b0;
      end else begin
         if (!wd_run)               wd_cnt <= '0;
         else if (wd_cnt != WD_LIM) wd_cnt <= wd_cnt + 1'b1;
         if (wd_run && (wd_cnt == WD_LAST)) timeout_r <= 1'b1;
      end
   end
`else
   // No watchdog: this evaluates to 0 for any legal TIMEOUT.
   assign timeout = (TIMEOUT < 0);
`endif
endmodule

// File: tb/tb_stream_pair_harness.sv
// Directed bench for stream_pair_harness. A small in-order unit model performs
// a float32 multiply on exact small values. Expected products are hand-computed
// constants.
`timescale 1ns/1ps
module tb_stream_pair_harness;
   localparam int W  = 32;
   localparam int D  = 4;
   localparam int CW = 4;
   localparam int TO = 16;

   logic          clk, rst;
   logic [W-1:0]  input_a, input_b, unit_a, unit_b, unit_z, output_z;
   logic          input_a_stb, input_a_ack, input_b_stb, input_b_ack;
   logic          unit_a_stb, unit_a_ack, unit_b_stb, unit_b_ack;
   logic          unit_z_stb, unit_z_ack, output_z_stb, output_z_ack;
   logic [CW-1:0] issued_count, completed_count;
   logic          timeout;

   stream_pair_harness #(.WIDTH(W), .DEPTH(D), .CNT_W(CW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
      .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
      .unit_a(unit_a), .unit_a_stb(unit_a_stb), .unit_a_ack(unit_a_ack),
      .unit_b(unit_b), .unit_b_stb(unit_b_stb), .unit_b_ack(unit_b_ack),
      .unit_z(unit_z), .unit_z_stb(unit_z_stb), .unit_z_ack(unit_z_ack),
      .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack),
      .issued_count(issued_count), .completed_count(completed_count),
      .timeout(timeout));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // float constants: 1.0 2.0 3.0 4.0 5.0 6.0 0.5
   localparam logic [31:0] F1 = 32'h3F800000, F2 = 32'h40000000, F3 = 32'h40400000;
   localparam logic [31:0] F4 = 32'h40800000, F5 = 32'h40A00000, F6 = 32'h40C00000;
   localparam logic [31:0] FH = 32'h3F000000;
   logic [31:0] ta [6];
   logic [31:0] tb [6];
   logic [31:0] te [6];

   int n_vec = 0;
   int n_miss = 0;

   task automatic check_val(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
      n_vec++;
      if (got_v !== exp_v) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
      end
   endtask

   // float32 multiply for normal operands whose product is exact
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] p;
      logic [9:0]  e;
      p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
      if (p[47]) return {a[31] ^ b[31], e[7:0] + 8'd1, p[46:24]};
      else       return {a[31] ^ b[31], e[7:0], p[45:23]};
   endfunction

   // environment state
   logic [31:0] q_a[$], q_b[$], got[$];
   bit env_clr, no_ret, sink_en;
   int dly_a, dly_b, viol, a_acc, zo, wa, wb, cd;
   bit iax, ibx, ax, bx, zx, ox, have_a, have_b, busy;
   logic [31:0] a_cap, b_cap, o_cap, ra, rb, res;

   // sources, unit model and sink, all updated on the falling edge
   initial begin
      input_a = '0; input_b = '0; input_a_stb = 0; input_b_stb = 0;
      unit_a_ack = 0; unit_b_ack = 0; unit_z = '0; unit_z_stb = 0; output_z_ack = 0;
      iax = 0; ibx = 0; ax = 0; bx = 0; zx = 0; ox = 0; have_a = 0; have_b = 0; busy = 0;
      zo = 0; wa = 0; wb = 0; cd = 0;
      forever begin
         @(negedge clk);
         if (env_clr) begin
            input_a_stb = 0; input_b_stb = 0; unit_a_ack = 0; unit_b_ack = 0;
            unit_z_stb = 0; output_z_ack = 0;
            iax = 0; ibx = 0; ax = 0; bx = 0; zx = 0; ox = 0;
            have_a = 0; have_b = 0; busy = 0; zo = 0; wa = 0; wb = 0; cd = 0;
            continue;
         end
         if (iax) begin void'(q_a.pop_front()); a_acc++; end
         if (ibx) void'(q_b.pop_front());
         if (ax) begin have_a = 1; ra = a_cap; end
         if (bx) begin have_b = 1; rb = b_cap; end
         if (zx) begin unit_z_stb = 0; busy = 0; zo++; end
         if (ox) begin got.push_back(o_cap); zo--; end
         if (have_a && have_b && !busy) begin
            res = fmul(ra, rb); have_a = 0; have_b = 0; busy = 1; cd = 5;
         end
         if (busy && !unit_z_stb && !no_ret) begin
            if (cd > 1) cd--;
            else begin unit_z_stb = 1; unit_z = res; end
         end
         if (q_a.size() > 0) begin input_a = q_a[0]; input_a_stb = 1; end else input_a_stb = 0;
         if (q_b.size() > 0) begin input_b = q_b[0]; input_b_stb = 1; end else input_b_stb = 0;
         if (unit_a_stb && !have_a) begin
            if (wa >= dly_a) unit_a_ack = 1; else begin unit_a_ack = 0; wa++; end
         end else begin unit_a_ack = 0; wa = 0; end
         if (unit_b_stb && !have_b) begin
            if (wb >= dly_b) unit_b_ack = 1; else begin unit_b_ack = 0; wb++; end
         end else begin unit_b_ack = 0; wb = 0; end
         output_z_ack = sink_en;
         if (unit_z_ack && zo >= D) viol++;
         iax = input_a_stb && input_a_ack;
         ibx = input_b_stb && input_b_ack;
         ax = unit_a_stb && unit_a_ack; a_cap = unit_a;
         bx = unit_b_stb && unit_b_ack; b_cap = unit_b;
         zx = unit_z_stb && unit_z_ack;
         ox = output_z_stb && output_z_ack; o_cap = output_z;
      end
   end

   task automatic do_reset(input bit chk_state);
      @(posedge clk); #2;
      rst = 1; env_clr = 1;
      q_a.delete(); q_b.delete(); got.delete();
      @(posedge clk); #1;
      if (chk_state) begin
         check_val("rst_in_a_ack", 32'(input_a_ack), 0);
         check_val("rst_in_b_ack", 32'(input_b_ack), 0);
         check_val("rst_unit_a_stb", 32'(unit_a_stb), 0);
         check_val("rst_unit_b_stb", 32'(unit_b_stb), 0);
         check_val("rst_unit_z_ack", 32'(unit_z_ack), 0);
         check_val("rst_out_z_stb", 32'(output_z_stb), 0);
         check_val("rst_out_z", output_z, 0);
         check_val("rst_unit_a", unit_a, 0);
         check_val("rst_issued", 32'(issued_count), 0);
         check_val("rst_completed", 32'(completed_count), 0);
         check_val("rst_timeout", 32'(timeout), 0);
      end
      #1;
      rst = 0; env_clr = 0; dly_a = 0; dly_b = 0; no_ret = 0; sink_en = 1; viol = 0; a_acc = 0;
      @(posedge clk); #2;
   endtask

   task automatic wait_got(input string tag, input int n, input int budget);
      int k;
      k = 0;
      while (got.size() < n && k < budget) begin @(posedge clk); #2; k++; end
      check_val(tag, 32'(got.size()), 32'(n));
   endtask

   task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
      q_a.push_back(a); q_b.push_back(b);
   endtask

   initial begin
      ta = '{F1, F2, F3, F4, F5, F6};
      tb = '{F2, F3, F4, F5, F6, FH};
      te = '{32'h40000000, 32'h40C00000, 32'h41400000, 32'h41A00000, 32'h41F00000, 32'h40400000};
      rst = 1; env_clr = 1; no_ret = 0; sink_en = 1; dly_a = 0; dly_b = 0; viol = 0; a_acc = 0;

      // reset state
      do_reset(1);

      // single pair with issue latency
      push_pair(F2, F3);
      @(posedge clk); #1;
      check_val("lat_a_stb_T", 32'(unit_a_stb), 0);
      @(posedge clk); #1;
      check_val("lat_a_stb_T1", 32'(unit_a_stb), 1);
      check_val("lat_b_stb_T1", 32'(unit_b_stb), 1);
      check_val("lat_unit_a", unit_a, F2);
      wait_got("single_wait", 1, 100);
      if (got.size() > 0) check_val("single_z", got[0], 32'h40C00000);
      check_val("single_issued", 32'(issued_count), 1);
      check_val("single_completed", 32'(completed_count), 1);

      // skewed operands
      do_reset(0);
      for (int i = 0; i < 6; i++) q_a.push_back(ta[i]);
      repeat (20) @(posedge clk);
      #2;
      check_val("skew_a_accepted", 32'(a_acc), 4);
      check_val("skew_a_ack_low", 32'(input_a_ack), 0);
      check_val("skew_no_issue", 32'(issued_count), 0);
      for (int i = 0; i < 6; i++) q_b.push_back(tb[i]);
      wait_got("skew_wait", 6, 500);
      for (int i = 0; i < 6; i++)
         if (i < got.size()) check_val($sformatf("skew_z%0d", i), got[i], te[i]);
      check_val("skew_issued", 32'(issued_count), 6);

      // sink backpressure
      do_reset(0);
      sink_en = 0;
      for (int i = 0; i < 10; i++) push_pair(ta[i % 6], tb[i % 6]);
      repeat (100) @(posedge clk);
      #2;
      check_val("bp_issued", 32'(issued_count), 4);
      check_val("bp_none_out", 32'(got.size()), 0);
      check_val("bp_z_stb", 32'(output_z_stb), 1);
      sink_en = 1;
      wait_got("bp_wait", 10, 800);
      for (int i = 0; i < 10; i++)
         if (i < got.size()) check_val($sformatf("bp_z%0d", i), got[i], te[i % 6]);
      check_val("bp_completed", 32'(completed_count), 10);
      check_val("bp_zack_when_full", 32'(viol), 0);

      // independent unit acks
      do_reset(0);
      dly_a = 0; dly_b = 3;
      push_pair(F2, F3);
      wait_got("ind_wait1", 1, 100);
      check_val("ind_issued1", 32'(issued_count), 1);
      dly_b = 0;
      push_pair(F3, F4);
      wait_got("ind_wait2", 2, 100);
      check_val("ind_issued2", 32'(issued_count), 2);
      push_pair(F5, F6);
      wait_got("ind_wait3", 3, 100);
      check_val("ind_issued3", 32'(issued_count), 3);
      if (got.size() >= 3) begin
         check_val("ind_z0", got[0], 32'h40C00000);
         check_val("ind_z1", got[1], 32'h41400000);
         check_val("ind_z2", got[2], 32'h41F00000);
      end
      repeat (10) @(posedge clk);
      #2;
      check_val("ind_no_extra", 32'(got.size()), 3);

      // counter wrap at CNT_W = 4
      do_reset(0);
      for (int i = 0; i < 17; i++) push_pair(F1, F1);
      wait_got("wrap_wait", 17, 1500);
      check_val("wrap_issued", 32'(issued_count), 1);
      check_val("wrap_completed", 32'(completed_count), 1);
      if (got.size() >= 17) check_val("wrap_z16", got[16], F1);

      // reset mid-flight with a unit that never answers
      do_reset(0);
      no_ret = 1;
      push_pair(F2, F3);
      begin
         int k;
         k = 0;
         while (issued_count != 1 && k < 50) begin @(posedge clk); #1; k++; end
      end
      check_val("mid_issued", 32'(issued_count), 1);
      for (int i = 0; i < 3; i++) q_a.push_back(ta[i]);
      repeat (15) @(posedge clk);
      #1;
      check_val("mid_timeout_pre", 32'(timeout), 0);
      check_val("mid_zack", 32'(unit_z_ack), 1);
      @(posedge clk); #1;
`ifdef HARNESS_WATCHDOG_EN
      check_val("wd_timeout_set", 32'(timeout), 1);
      repeat (20) @(posedge clk);
      #1;
      check_val("wd_timeout_sticky", 32'(timeout), 1);
`else
      check_val("no_wd_timeout", 32'(timeout), 0);
`endif
      do_reset(1);
      repeat (20) @(posedge clk);
      #2;
      check_val("post_rst_issued", 32'(issued_count), 0);
      check_val("post_rst_z_stb", 32'(output_z_stb), 0);
      check_val("post_rst_a_stb", 32'(unit_a_stb), 0);
      check_val("post_rst_a_ack", 32'(input_a_ack), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit: got expired expected finish");
      $fatal(1, "time limit");
   end
endmodule
